// File: rtl/edge_pkg.sv
// Shared defaults and tap addressing for the edge-detector window datapath.
package edge_pkg;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_LINE_WORDS = 160;
    localparam int DEF_ROWS       = 3;
    localparam int DEF_COLS       = 2;
    localparam int DEF_CNT_W      = 16;

    // Bit offset of tap (r,c) inside the flattened window; r=0 newest line, c=0 newest word.
    function automatic int tap_off(input int r, input int c, input int cols, input int word_w);
        return (r * cols + c) * word_w;
    endfunction

endpackage

// File: rtl/window_data_path_line_shift_buffer.sv
// line_shift_buffer: write-enabled fixed-depth word delay.
// Read-before-write on a circular pointer; dout is registered, so the value
// appears one write later than the slot was read. Storage has no reset.
module line_shift_buffer #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 159
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     ptr;

    // Storage: return the word written DEPTH writes ago, then overwrite its slot.
    always_ff @(posedge clk) begin
        if (write_en) begin
            dout     <= mem[ptr];
            mem[ptr] <= din;
        end
    end

    // Circular slot pointer, advances once per write.
    always_ff @(posedge clk) begin
        if (reset)
            ptr <= '0;
        else if (write_en)
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/window_data_path.sv
// window_data_path: sliding ROWS x COLS word window over a raster stream.
// Optional build macro: BORDER_ZERO_EN (zero taps outside the frame/line and
// deliver every window; otherwise win_valid only for fully populated windows).
//
// Each row r has a "head" register holding tap (r,0) after a write. Row 0's head
// is loaded from data_in; row r>0's head is the registered output of a line
// buffer fed by row r-1's head *before* its update (one write late), so those
// buffers are LINE_WORDS-1 deep to total a delay of exactly LINE_WORDS writes.
// Taps c>=1 are a shift of the head, again taking the pre-update value.
module window_data_path
    import edge_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ROWS       = DEF_ROWS,
    parameter int COLS       = DEF_COLS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_en,
    input  logic                          sof,
    input  logic [WORD_W-1:0]             data_in,
    output logic [ROWS*COLS*WORD_W-1:0]   win,
    output logic                          win_valid,
    output logic [CNT_W-1:0]              col_idx,
    output logic [CNT_W-1:0]              row_idx,
    output logic                          eol
);

    // Reset wins over a same-cycle write, so the datapath never advances in reset.
    logic                        wr;
    logic [CNT_W-1:0]            col_cnt, row_cnt;
    logic [CNT_W-1:0]            cur_col, cur_row;
    logic                        last_col;
    logic                        vld_nxt;
    logic [ROWS-1:0][COLS-1:0]   mask_nxt, mask_q;

    assign wr = write_en & ~reset;

    // Position of the word being accepted; sof restarts the frame at (0,0).
    always_comb begin
        cur_col  = sof ? '0 : col_cnt;
        cur_row  = sof ? '0 : row_cnt;
        last_col = (cur_col == CNT_W'(LINE_WORDS - 1));
    end

    // Tap qualification and window validity for the word being accepted.
    always_comb begin
        mask_nxt = '1;
        vld_nxt  = 1'b0;
`ifdef BORDER_ZERO_EN
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                mask_nxt[r][c] = (CNT_W'(r) <= cur_row) && (CNT_W'(c) <= cur_col);
        vld_nxt = 1'b1;
`else
        vld_nxt = (cur_row >= CNT_W'(ROWS - 1)) && (cur_col >= CNT_W'(COLS - 1));
`endif
    end

    // Column/row counters for the next word; row saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (wr) begin
            col_cnt <= last_col ? '0 : cur_col + 1'b1;
            row_cnt <= (last_col && !(&cur_row)) ? cur_row + 1'b1 : cur_row;
        end
    end

    // Output registers: positions and mask hold on idle cycles, pulses drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            eol       <= 1'b0;
            col_idx   <= '0;
            row_idx   <= '0;
            mask_q    <= '0;
        end else begin
            win_valid <= wr & vld_nxt;
            eol       <= wr & last_col;
            if (wr) begin
                col_idx <= cur_col;
                row_idx <= cur_row;
                mask_q  <= mask_nxt;
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [WORD_W-1:0]            head;
        logic [COLS-1:0][WORD_W-1:0]  taps;

        if (r == 0) begin : g_src
            // Newest word of the current line.
            always_ff @(posedge clk) begin
                if (wr) head <= data_in;
            end
        end else begin : g_lb
            line_shift_buffer #(
                .WORD_W (WORD_W),
                .DEPTH  (LINE_WORDS - 1)
            ) u_lb (
                .clk      (clk),
                .reset    (reset),
                .write_en (wr),
                .din      (g_row[r-1].head),
                .dout     (head)
            );
        end

        if (COLS == 1) begin : g_nosh
            assign taps = head;
        end else begin : g_sh
            logic [COLS-2:0][WORD_W-1:0] sh_q;
            // Older words of this row: shift in the head value before it updates.
            always_ff @(posedge clk) begin
                if (wr) begin
                    sh_q[0] <= head;
                    for (int i = 1; i < COLS - 1; i++)
                        sh_q[i] <= sh_q[i-1];
                end
            end
            assign taps = {sh_q, head};
        end

        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign win[tap_off(r, c, COLS, WORD_W) +: WORD_W] = taps[c] & {WORD_W{mask_q[r][c]}};
        end
    end

endmodule

// File: tb/tb_window_data_path.sv
// Directed bench for window_data_path with a scoreboard of expected outputs.
// Honours BORDER_ZERO_EN the same way as the design build.
module tb_window_data_path;

    localparam int WORD_W = 32;
    localparam int LW     = 4;
    localparam int ROWS   = 3;
    localparam int COLS   = 2;
    localparam int CNT_W  = 4;
    localparam int WIN_W  = ROWS * COLS * WORD_W;
    localparam int ROW_MAX = (1 << CNT_W) - 1;
`ifdef BORDER_ZERO_EN
    localparam bit BZ = 1'b1;
`else
    localparam bit BZ = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, write_en, sof;
    logic [WORD_W-1:0] data_in;
    logic [WIN_W-1:0]  win;
    logic              win_valid, eol;
    logic [CNT_W-1:0]  col_idx, row_idx;

    window_data_path #(
        .WORD_W(WORD_W), .LINE_WORDS(LW), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .write_en(write_en), .sof(sof), .data_in(data_in),
        .win(win), .win_valid(win_valid), .col_idx(col_idx), .row_idx(row_idx), .eol(eol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic             eol;
        logic [CNT_W-1:0] col;
        logic [CNT_W-1:0] row;
        logic [WIN_W-1:0] win;
        bit               win_chk;
    } exp_t;

    exp_t              exp_q[$];
    exp_t              held;
    logic [WORD_W-1:0] hist[$];
    int                m_col, m_row;
    int                checks, passes, sn, wn;

    function automatic logic [WORD_W-1:0] tap(input int r, input int c);
        return win[(r * COLS + c) * WORD_W +: WORD_W];
    endfunction

    task automatic chk(input string tag, input logic [WIN_W-1:0] obs, input logic [WIN_W-1:0] expv);
        checks++;
        assert (obs === expv) begin
            passes++;
        end else begin
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    task automatic cmp_out(input exp_t e);
        string t;
        t = $sformatf("s%0d", sn);
        chk({t, "_vld"}, WIN_W'(win_valid), WIN_W'(e.vld));
        chk({t, "_eol"}, WIN_W'(eol),       WIN_W'(e.eol));
        chk({t, "_col"}, WIN_W'(col_idx),   WIN_W'(e.col));
        chk({t, "_row"}, WIN_W'(row_idx),   WIN_W'(e.row));
        if (e.win_chk) chk({t, "_win"}, win, e.win);
    endtask

    // One cycle of stimulus; expected result is queued at drive time, checked at output.
    task automatic step(input bit we, input bit s, input logic [WORD_W-1:0] d);
        exp_t e;
        int   cc, cr, idx;
        logic [WORD_W-1:0] w;
        reset = 1'b0; write_en = we; sof = s; data_in = d;
        e = held; e.vld = 1'b0; e.eol = 1'b0;
        if (we) begin
            cc = s ? 0 : m_col;
            cr = s ? 0 : m_row;
            hist.push_back(d);
            e.col = CNT_W'(cc);
            e.row = CNT_W'(cr);
            e.eol = (cc == LW - 1);
            e.vld = BZ ? 1'b1 : (cr >= ROWS - 1 && cc >= COLS - 1);
            e.win_chk = e.vld;
            e.win = '0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    idx = hist.size() - 1 - (r * LW + c);
                    w = (idx >= 0) ? hist[idx] : '0;
                    if (BZ && (r > cr || c > cc)) w = '0;
                    e.win[(r * COLS + c) * WORD_W +: WORD_W] = w;
                end
            if (cc == LW - 1) begin
                m_col = 0;
                m_row = (cr == ROW_MAX) ? ROW_MAX : cr + 1;
            end else begin
                m_col = cc + 1;
                m_row = cr;
            end
            held = e;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        sn++;
        cmp_out(exp_q.pop_front());
    endtask

    task automatic do_reset(input bit we, input logic [WORD_W-1:0] d);
        exp_t e;
        reset = 1'b1; write_en = we; sof = 1'b0; data_in = d;
        e.vld = 1'b0; e.eol = 1'b0; e.col = '0; e.row = '0; e.win = '0; e.win_chk = 1'b1;
        m_col = 0; m_row = 0;
        held = e;
        exp_q.push_back(e);
        @(posedge clk); #1;
        sn++;
        cmp_out(exp_q.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0; passes = 0; sn = 0; m_col = 0; m_row = 0;
        reset = 1'b1; write_en = 1'b0; sof = 1'b0; data_in = '0;
        @(posedge clk); #1;
        do_reset(1'b0, '0);

        // Continuous stream 1..19, sof on the first word.
        for (int n = 1; n <= 19; n++) begin
            step(1'b1, n == 1, WORD_W'(n));
            if (n == 10) begin
                chk("w10_tap21", WIN_W'(tap(2, 1)), WIN_W'(1));
                chk("w10_col",   WIN_W'(col_idx),   WIN_W'(1));
                chk("w10_row",   WIN_W'(row_idx),   WIN_W'(2));
                chk("w10_vld",   WIN_W'(win_valid), WIN_W'(1));
            end
`ifndef BORDER_ZERO_EN
            if (n == 9)  chk("w9_vld",  WIN_W'(win_valid), WIN_W'(0));
            if (n == 13) chk("w13_vld", WIN_W'(win_valid), WIN_W'(0));
`else
            if (n == 1) chk("bz_w1", win, WIN_W'(1));
            if (n == 5) begin
                chk("bz_w5_t10", WIN_W'(tap(1, 0)), WIN_W'(1));
                chk("bz_w5_t01", WIN_W'(tap(0, 1)), WIN_W'(0));
                chk("bz_w5_t11", WIN_W'(tap(1, 1)), WIN_W'(0));
            end
`endif
            if (n == 12 || n == 16) chk($sformatf("w%0d_eol", n), WIN_W'(eol), WIN_W'(1));
        end

        // Mid-frame sof at word 20.
        step(1'b1, 1'b1, WORD_W'(20));
        chk("w20_col", WIN_W'(col_idx), WIN_W'(0));
        chk("w20_row", WIN_W'(row_idx), WIN_W'(0));
        for (int n = 21; n <= 30; n++) step(1'b1, 1'b0, WORD_W'(n));

        // write_en toggling, plus an ignored sof on an idle cycle.
        for (int n = 31; n <= 50; n++) begin
            step(1'b1, 1'b0, WORD_W'(n));
            step(1'b0, (n == 37), 32'hdead_beef);
        end

        // sof on a word that would otherwise close the line: sof wins.
        wn = 51;
        for (int k = 0; k < LW && m_col != LW - 1; k++) begin
            step(1'b1, 1'b0, WORD_W'(wn)); wn++;
        end
        step(1'b1, 1'b1, WORD_W'(wn)); wn++;
        chk("sofwrap_col", WIN_W'(col_idx), WIN_W'(0));
        chk("sofwrap_eol", WIN_W'(eol),     WIN_W'(0));
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, WORD_W'(wn)); wn++;
        end

        // Reset together with a write: the write is dropped, next word is (0,0).
        do_reset(1'b1, WORD_W'(wn)); wn++;
        step(1'b1, 1'b0, WORD_W'(wn)); wn++;
        chk("postrst_col", WIN_W'(col_idx), WIN_W'(0));
        chk("postrst_row", WIN_W'(row_idx), WIN_W'(0));

        // Long run with random gaps, no sof: row counter saturates.
        for (int k = 0; k < 80; k++) begin
            step(1'b1, 1'b0, $urandom);
            if ($urandom_range(0, 2) == 0) step(1'b0, 1'b0, $urandom);
        end
        chk("row_sat", WIN_W'(row_idx), WIN_W'(ROW_MAX));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
